// File: rtl/proximity_filter_pkg.sv
// Shared definitions for the proximity filter.
//   state_e   : FSM state encoding, also exported on state_dbg
//   MS_PER_S  : milliseconds per second, used for dwell scaling
//   max_int   : constant-foldable max, used to size counters
package proximity_filter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ARMING    = 3'd1,
    ST_PRESENT   = 3'd2,
    ST_RELEASING = 3'd3,
    ST_COOLDOWN  = 3'd4
  } state_e;

  localparam int MS_PER_S = 1000;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler producing a one-cycle tick every DIV cycles.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   tick  : registered one-cycle pulse, period DIV cycles
module tick_gen #(
  parameter int DIV = 50000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;

  // NOTE: sequential state is always written with non-blocking assignments so
  // every register samples the pre-edge value of its inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      tick  <= 1'b0;
    end else begin
      if (cnt_q == LAST) cnt_q <= '0;
      else               cnt_q <= cnt_q + CW'(1);
      tick <= (cnt_q == LAST);
    end
  end

endmodule

// File: rtl/proximity_filter.sv
// Debounces a raw object-detect level sampled on sensor strobes into a
// presence state with approach/leave/hold events, dwell seconds and a
// missing-strobe fault.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   sample_strobe   : one-cycle pulse marking a new measurement
//   object_raw      : raw detect level, asynchronous to clk
//   present         : debounced presence level
//   approach_pulse  : one cycle when presence is declared
//   leave_pulse     : one cycle on entry to cooldown
//   hold_pulse      : one cycle when a visit reaches HOLD_MS (once per visit)
//   dwell_s         : whole seconds of current/last visit, saturating
//   sensor_fault    : no strobe for STROBE_TO_MS
//   state_dbg       : current state encoding
module proximity_filter
  import proximity_filter_pkg::*;
#(
  parameter int CLK_FREQ     = 50000000,
  parameter int N_ON         = 4,
  parameter int N_OFF        = 4,
  parameter int HOLD_MS      = 2000,
  parameter int COOLDOWN_MS  = 1000,
  parameter int STROBE_TO_MS = 100,
  parameter int DWELL_W      = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sample_strobe,
  input  logic               object_raw,
  output logic               present,
  output logic               approach_pulse,
  output logic               leave_pulse,
  output logic               hold_pulse,
  output logic [DWELL_W-1:0] dwell_s,
  output logic               sensor_fault,
  output logic [2:0]         state_dbg
);

  localparam int MS_MAX = max_int(HOLD_MS, max_int(COOLDOWN_MS, STROBE_TO_MS));
  localparam int MS_W   = $clog2(MS_MAX + 1);
  localparam int CNT_W  = $clog2(max_int(N_ON, N_OFF) + 1);
  localparam int SEC_W  = $clog2(MS_PER_S);

  localparam logic [MS_W-1:0]  HOLD_LIM = MS_W'(HOLD_MS);
  localparam logic [MS_W-1:0]  CD_LIM   = MS_W'(COOLDOWN_MS);
  localparam logic [MS_W-1:0]  GAP_LIM  = MS_W'(STROBE_TO_MS);
  localparam logic [CNT_W-1:0] ON_LIM   = CNT_W'(N_ON);
  localparam logic [CNT_W-1:0] OFF_LIM  = CNT_W'(N_OFF);
  localparam logic [SEC_W-1:0] SEC_LAST = SEC_W'(MS_PER_S - 1);

  logic tick;

  tick_gen #(.DIV(CLK_FREQ / 1000)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  // Two-flop synchronizer; obj is the only view of object_raw used below.
  logic obj_meta, obj;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      obj_meta <= 1'b0;
      obj      <= 1'b0;
    end else begin
      obj_meta <= object_raw;
      obj      <= obj_meta;
    end
  end

  // ms_q times the visit (towards HOLD_MS) and is reused in COOLDOWN.
  state_e             state_q, state_n;
  logic [CNT_W-1:0]   cnt_q, cnt_n;
  logic [MS_W-1:0]    ms_q, ms_n;
  logic [MS_W-1:0]    gap_q, gap_n;
  logic [SEC_W-1:0]   sec_q, sec_n;
  logic [DWELL_W-1:0] dwell_n;
  logic               hold_done_q, hold_done_n;
  logic               fault_n, approach_n, leave_n, hold_n;
  logic               timeout, go_present, go_cooldown, in_visit;

  // NOTE: every variable assigned in this block gets a default first, so no
  // path can leave one unassigned and infer a latch.
  always_comb begin
    state_n     = state_q;
    cnt_n       = cnt_q;
    ms_n        = ms_q;
    gap_n       = gap_q;
    sec_n       = sec_q;
    dwell_n     = dwell_s;
    hold_done_n = hold_done_q;
    fault_n     = sensor_fault;
    approach_n  = 1'b0;
    leave_n     = 1'b0;
    hold_n      = 1'b0;
    timeout     = 1'b0;
    go_present  = 1'b0;
    go_cooldown = 1'b0;
    in_visit    = (state_q == ST_PRESENT) || (state_q == ST_RELEASING);

    // Strobe watchdog: a sample in the same cycle always beats the timeout.
    if (sample_strobe) begin
      gap_n   = '0;
      fault_n = 1'b0;
    end else if (tick && gap_q != GAP_LIM) begin
      gap_n = gap_q + MS_W'(1);
      if (gap_n == GAP_LIM) begin
        timeout = 1'b1;
        fault_n = 1'b1;
      end
    end

    // Visit timing keeps running through RELEASING.
    if (in_visit && tick) begin
      if (ms_q != HOLD_LIM) begin
        ms_n = ms_q + MS_W'(1);
        if (ms_n == HOLD_LIM && !hold_done_q) begin
          hold_n      = 1'b1;
          hold_done_n = 1'b1;
        end
      end
      if (sec_q == SEC_LAST) begin
        sec_n = '0;
        if (dwell_s != '1) dwell_n = dwell_s + DWELL_W'(1);
      end else begin
        sec_n = sec_q + SEC_W'(1);
      end
    end

    unique case (state_q)
      ST_IDLE: begin
        if (sample_strobe && obj) begin
          if (N_ON == 1) go_present = 1'b1;
          else begin
            state_n = ST_ARMING;
            cnt_n   = CNT_W'(1);
          end
        end else if (timeout) begin
          cnt_n = '0;
        end
      end
      ST_ARMING: begin
        if (sample_strobe) begin
          if (obj) begin
            cnt_n = cnt_q + CNT_W'(1);
            if (cnt_n == ON_LIM) go_present = 1'b1;
          end else begin
            state_n = ST_IDLE;
            cnt_n   = '0;
          end
        end else if (timeout) begin
          state_n = ST_IDLE;
          cnt_n   = '0;
        end
      end
      ST_PRESENT: begin
        if (sample_strobe && !obj) begin
          if (N_OFF == 1) go_cooldown = 1'b1;
          else begin
            state_n = ST_RELEASING;
            cnt_n   = CNT_W'(1);
          end
        end else if (timeout) begin
          go_cooldown = 1'b1;
        end
      end
      ST_RELEASING: begin
        if (sample_strobe) begin
          if (obj) begin
            state_n = ST_PRESENT;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt_q + CNT_W'(1);
            if (cnt_n == OFF_LIM) go_cooldown = 1'b1;
          end
        end else if (timeout) begin
          go_cooldown = 1'b1;
        end
      end
      ST_COOLDOWN: begin
        // Samples are ignored here; only ticks move the state on.
        if (ms_q >= CD_LIM) begin
          state_n = ST_IDLE;
          cnt_n   = '0;
        end else if (tick) begin
          ms_n = ms_q + MS_W'(1);
          if (ms_n == CD_LIM) begin
            state_n = ST_IDLE;
            cnt_n   = '0;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase

    if (go_present) begin
      state_n     = ST_PRESENT;
      approach_n  = 1'b1;
      cnt_n       = '0;
      ms_n        = '0;
      sec_n       = '0;
      dwell_n     = '0;
      hold_done_n = 1'b0;
    end
    // hold_n is left as computed so hold and leave may coincide.
    if (go_cooldown) begin
      state_n = ST_COOLDOWN;
      leave_n = 1'b1;
      cnt_n   = '0;
      ms_n    = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      ms_q           <= '0;
      gap_q          <= '0;
      sec_q          <= '0;
      hold_done_q    <= 1'b0;
      dwell_s        <= '0;
      sensor_fault   <= 1'b0;
      present        <= 1'b0;
      approach_pulse <= 1'b0;
      leave_pulse    <= 1'b0;
      hold_pulse     <= 1'b0;
    end else begin
      state_q        <= state_n;
      cnt_q          <= cnt_n;
      ms_q           <= ms_n;
      gap_q          <= gap_n;
      sec_q          <= sec_n;
      hold_done_q    <= hold_done_n;
      dwell_s        <= dwell_n;
      sensor_fault   <= fault_n;
      present        <= (state_n == ST_PRESENT) || (state_n == ST_RELEASING);
      approach_pulse <= approach_n;
      leave_pulse    <= leave_n;
      hold_pulse     <= hold_n;
    end
  end

  assign state_dbg = state_q;

endmodule
